// File: rtl/div_pkg.sv
// Shared definitions for the division scheduler and its serial divider:
// FSM encodings and the quotient reported for a zero divisor.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_BUSY,
    S_RESP
  } sched_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_PREP,
    D_CALC,
    D_FIN
  } div_state_e;

  localparam int unsigned MAX_DATA_W = 64;

  // Sliced down to DATA_W by users; supports widths up to MAX_DATA_W.
  localparam logic [MAX_DATA_W-1:0] ZERO_DIV_QUOTIENT = '1;

endpackage

// File: rtl/div_serial.sv
// Radix-2 restoring divider, one quotient bit per cycle. done rises DATA_W+2
// edges after the start edge and stays high until the next start.
module div_serial
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic              sign_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] q_out_q, q_out_d;
  logic [DATA_W-1:0] r_out_q, r_out_d;
  logic              sign_q, sign_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q <= D_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  // quo_q doubles as the dividend shift register while the quotient fills in.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    done_d  = done_q;
    case (state_q)
      D_IDLE: begin
        if (start_i) begin
          quo_d   = dividend_i;
          dvs_d   = divisor_i;
          sign_d  = sign_i;
          neg_d   = sign_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
          done_d  = 1'b0;
          state_d = D_PREP;
        end
      end
      D_PREP: begin
        if (sign_q && quo_q[DATA_W-1]) quo_d = -quo_q;
        if (sign_q && dvs_q[DATA_W-1]) dvs_d = -dvs_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = D_CALC;
      end
      D_CALC: begin
        if (!trial[DATA_W]) begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = shifted[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = D_FIN;
      end
      D_FIN: begin
        // Remainder stays an unsigned magnitude; only the quotient takes a sign.
        q_out_d = neg_q ? -quo_q : quo_q;
        r_out_d = rem_q;
        done_d  = 1'b1;
        state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  assign done_o      = done_q;
  assign quotient_o  = q_out_q;
  assign remainder_o = r_out_q;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one serial divider among N_REQ requesters;
// zero divisors are answered directly without starting the divider.
module div_sched
  import div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_sign,
  input  logic [N_REQ*DATA_W-1:0] req_dividend,
  input  logic [N_REQ*DATA_W-1:0] req_divisor,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       quotient,
  output logic [DATA_W-1:0]       remainder,
  output logic                    busy
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CAND_W = IDX_W + 1;

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [CAND_W-1:0] cand;
  logic [DATA_W-1:0] win_dividend;
  logic [DATA_W-1:0] win_divisor;
  logic              div_start;
  logic              div_done;
  logic              div_arst;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      owner_q      <= '0;
      sign_q       <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      sign_q       <= sign_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
    end
  end

  // Walk downward so the candidate nearest last_grant+1 is written last and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant_q} + CAND_W'(k);
      if (cand >= CAND_W'(N_REQ)) cand = cand - CAND_W'(N_REQ);
      if (req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_dividend = req_dividend[int'(grant_idx)*DATA_W +: DATA_W];
  assign win_divisor  = req_divisor[int'(grant_idx)*DATA_W +: DATA_W];

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    sign_d       = sign_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    req_ready    = '0;
    rsp_valid    = '0;
    div_start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          sign_d       = req_sign[grant_idx];
          dividend_d   = win_dividend;
          divisor_d    = win_divisor;
          if (win_divisor == '0) begin
            quot_d  = ZERO_DIV_QUOTIENT[DATA_W-1:0];
            rem_d   = win_dividend;
            state_d = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        div_start = 1'b1;
        state_d   = S_ARM;
      end
      // done may still be high from the previous division; wait one cycle.
      S_ARM: state_d = S_BUSY;
      S_BUSY: begin
        if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_arst  = ~rst;

  div_serial #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk         (clk),
    .arst_i      (div_arst),
    .start_i     (div_start),
    .sign_i      (sign_q),
    .dividend_i  (dividend_q),
    .divisor_i   (divisor_q),
    .done_o      (div_done),
    .quotient_o  (div_quotient),
    .remainder_o (div_remainder)
  );

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: reset, unsigned/signed division, zero divisor,
// round-robin order, reset mid-division and a held response.
module tb_div_sched;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int LAT = DW + 5;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_sign;
  logic [NR*DW-1:0] req_dividend;
  logic [NR*DW-1:0] req_divisor;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [DW-1:0]    quotient;
  logic [DW-1:0]    remainder;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  div_sched #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sign     (req_sign),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (dut.div_start === 1'b1) start_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one request, waits for accept and response, completes the handshake.
  // wt = cycles waited for ready; lat = edges from accept edge to rsp_valid, inclusive.
  task automatic do_txn(input int i, input bit sgn, input logic [DW-1:0] dvd,
                        input logic [DW-1:0] dvs, output int wt, output int lat,
                        output logic [DW-1:0] q, output logic [DW-1:0] r,
                        output logic [NR-1:0] rv, output bit to);
    to = 1'b0; wt = 0; lat = 0; q = '0; r = '0; rv = '0;
    req_valid[i] = 1'b1;
    req_sign[i]  = sgn;
    req_dividend[i*DW +: DW] = dvd;
    req_divisor[i*DW +: DW]  = dvs;
    #1;
    while (req_ready[i] !== 1'b1 && wt < 100) begin
      @(negedge clk); #1; wt++;
    end
    if (req_ready[i] !== 1'b1) begin
      to = 1'b1; req_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    lat = 1;
    req_valid[i] = 1'b0;
    while (rsp_valid === '0 && lat < 100) begin
      @(negedge clk); lat++;
    end
    if (rsp_valid === '0) begin
      to = 1'b1;
      return;
    end
    rv = rsp_valid; q = quotient; r = remainder;
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  task automatic test_reset();
    int wt, lat; logic [DW-1:0] q, r; logic [NR-1:0] rv; bit to;
    rst = 1'b0; req_valid = '0; req_sign = '0; req_dividend = '0; req_divisor = '0; rsp_ready = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    total++; if (quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL reset_result: got q=%h r=%h want 0/0", quotient, remainder); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_txn(1, 1'b0, 32'd20, 32'd0, wt, lat, q, r, rv, to);
    total++; if (to || wt != 0) begin bad++; $display("FAIL first_accept: waited %0d timeout=%0d want 0", wt, to); end
    total++; if (lat != 1) begin bad++; $display("FAIL first_latency: got %0d want 1", lat); end
    total++; if (rv !== 4'b0010 || q !== 32'hFFFFFFFF || r !== 32'd20) begin
      bad++; $display("FAIL first_result: got rv=%b q=%h r=%h want 0010/ffffffff/14", rv, q, r); end
  endtask

  task automatic test_single();
    int wt, lat, sc; logic [DW-1:0] q, r; logic [NR-1:0] rv; bit to;
    logic [DW-1:0] dvd[2], dvs[2], eq[2], er[2];
    dvd = '{32'd100, 32'hFFFFFF9C}; dvs = '{32'd7, 32'd7};
    eq  = '{32'd14, 32'h24924916};  er  = '{32'd2, 32'd2};
    for (int k = 0; k < 2; k++) begin
      sc = start_cnt;
      do_txn(0, 1'b0, dvd[k], dvs[k], wt, lat, q, r, rv, to);
      total++; if (to || lat != LAT) begin
        bad++; $display("FAIL single_latency[%0d]: got %0d timeout=%0d want %0d", k, lat, to, LAT); end
      total++; if (rv !== 4'b0001 || q !== eq[k] || r !== er[k]) begin
        bad++; $display("FAIL single_result[%0d]: got rv=%b q=%h r=%h want 0001/%h/%h", k, rv, q, r, eq[k], er[k]); end
      total++; if (start_cnt - sc != 1) begin
        bad++; $display("FAIL single_start_pulses[%0d]: got %0d want 1", k, start_cnt - sc); end
    end
  endtask

  task automatic test_signed();
    int wt, lat; logic [DW-1:0] q, r; logic [NR-1:0] rv; bit to;
    logic [DW-1:0] dvd[3], dvs[3], eq[3];
    dvd = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C};
    dvs = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    eq  = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    for (int k = 0; k < 3; k++) begin
      do_txn(2, 1'b1, dvd[k], dvs[k], wt, lat, q, r, rv, to);
      total++; if (to || lat != LAT || rv !== 4'b0100 || q !== eq[k] || r !== 32'd2) begin
        bad++; $display("FAIL signed[%0d]: got lat=%0d rv=%b q=%h r=%h want %0d/0100/%h/2", k, lat, rv, q, r, LAT, eq[k]); end
    end
  endtask

  task automatic test_zero_div();
    int wt, lat, sc; logic [DW-1:0] q, r; logic [NR-1:0] rv; bit to;
    sc = start_cnt;
    do_txn(1, 1'b0, 32'd55, 32'd0, wt, lat, q, r, rv, to);
    total++; if (to || lat != 1) begin bad++; $display("FAIL zdiv_latency: got %0d timeout=%0d want 1", lat, to); end
    total++; if (rv !== 4'b0010 || q !== 32'hFFFFFFFF || r !== 32'd55) begin
      bad++; $display("FAIL zdiv_result: got rv=%b q=%h r=%h want 0010/ffffffff/37", rv, q, r); end
    total++; if (start_cnt != sc) begin bad++; $display("FAIL zdiv_start: got %0d pulses want 0", start_cnt - sc); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] gnt[5], rvs[5], egnt[5];
    logic [DW-1:0] qs[5], rs[5];
    logic [DW-1:0] dvd[NR], dvs[NR], eq[NR], er[NR];
    int ng, nr, eidx[5];
    dvd = '{32'd100, 32'd1000, 32'd7, 32'hFFFFFFFF};
    dvs = '{32'd7, 32'd10, 32'd9, 32'd16};
    eq  = '{32'd14, 32'd100, 32'd0, 32'h0FFFFFFF};
    er  = '{32'd2, 32'd0, 32'd7, 32'd15};
    egnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    eidx = '{0, 1, 2, 3, 0};
    ng = 0; nr = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1; req_sign[i] = 1'b0;
      req_dividend[i*DW +: DW] = dvd[i]; req_divisor[i*DW +: DW] = dvs[i];
    end
    rsp_ready = '1;
    for (int cyc = 0; cyc < 400 && nr < 5; cyc++) begin
      #1;
      if (req_ready !== '0 && ng < 5) begin gnt[ng] = req_ready; ng++; end
      if (rsp_valid !== '0) begin
        total++; if (req_ready !== '0) begin
          bad++; $display("FAIL rr_overlap: req_ready=%b during response, want 0000", req_ready); end
        rvs[nr] = rsp_valid; qs[nr] = quotient; rs[nr] = remainder; nr++;
      end
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = '0;
    total++; if (ng != 5 || nr != 5) begin bad++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 5/5", ng, nr); end
    for (int k = 0; k < ng; k++) begin
      total++; if (gnt[k] !== egnt[k]) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, gnt[k], egnt[k]); end
    end
    for (int k = 0; k < nr; k++) begin
      total++; if (rvs[k] !== egnt[k] || qs[k] !== eq[eidx[k]] || rs[k] !== er[eidx[k]]) begin
        bad++; $display("FAIL rr_result[%0d]: got rv=%b q=%h r=%h want %b/%h/%h",
                        k, rvs[k], qs[k], rs[k], egnt[k], eq[eidx[k]], er[eidx[k]]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int wt, lat, stale; logic [DW-1:0] q, r; logic [NR-1:0] rv; bit to;
    req_valid[0] = 1'b1; req_sign[0] = 1'b0;
    req_dividend[0 +: DW] = 32'd100; req_divisor[0 +: DW] = 32'd7;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rb_accept: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rb_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || rsp_valid !== '0 || quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL rb_async_reset: got busy=%b rv=%b q=%h r=%h want 0/0000/0/0", busy, rsp_valid, quotient, remainder); end
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    repeat (45) begin
      @(negedge clk);
      if (rsp_valid !== '0 || busy !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rb_stale: got %0d active cycles want 0", stale); end
    do_txn(3, 1'b0, 32'd9, 32'd3, wt, lat, q, r, rv, to);
    total++; if (to || wt != 0 || lat != LAT) begin
      bad++; $display("FAIL rb_latency: got wait=%0d lat=%0d want 0/%0d", wt, lat, LAT); end
    total++; if (rv !== 4'b1000 || q !== 32'd3 || r !== 32'd0) begin
      bad++; $display("FAIL rb_result: got rv=%b q=%h r=%h want 1000/3/0", rv, q, r); end
  endtask

  task automatic test_hold_resp();
    int wt, lat, n; logic [DW-1:0] q, r; logic [NR-1:0] rv; bit to;
    req_valid[1] = 1'b1; req_sign[1] = 1'b0;
    req_dividend[1*DW +: DW] = 32'd81; req_divisor[1*DW +: DW] = 32'd9;
    rsp_ready[1] = 1'b1;
    req_valid[0] = 1'b1; req_sign[0] = 1'b0;
    req_dividend[0 +: DW] = 32'd200; req_divisor[0 +: DW] = 32'd9;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL hold_accept: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid === '0 && n < 100) begin @(negedge clk); n++; end
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL hold_rsp: got %b want 0001", rsp_valid); end
    for (int c = 0; c < 10; c++) begin
      total++; if ({rsp_valid, req_ready, busy} !== 9'b0001_0000_1 || quotient !== 32'd22 || remainder !== 32'd2) begin
        bad++; $display("FAIL hold_stable[%0d]: got rv=%b rdy=%b busy=%b q=%h r=%h want 0001/0000/1/16/2",
                        c, rsp_valid, req_ready, busy, quotient, remainder); end
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    total++; if (rsp_valid !== '0 || req_ready !== 4'b0010) begin
      bad++; $display("FAIL hold_release: got rv=%b rdy=%b want 0000/0010", rsp_valid, req_ready); end
    do_txn(1, 1'b0, 32'd81, 32'd9, wt, lat, q, r, rv, to);
    total++; if (to || wt != 0 || lat != LAT || rv !== 4'b0010 || q !== 32'd9 || r !== 32'd0) begin
      bad++; $display("FAIL hold_next: got wait=%0d lat=%0d rv=%b q=%h r=%h want 0/%0d/0010/9/0", wt, lat, rv, q, r, LAT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_zero_div();
    test_round_robin();
    test_reset_busy();
    test_hold_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
